// File: rtl/hex_scan_driver_if.sv
// Bus between the hex PIO output word and the multiplexed display driver.
interface hex_scan_driver_if;
    logic [31:0] seg_word;
    logic        enable;
    logic [3:0]  brightness;
    logic [3:0]  blink_mask;
    logic [7:0]  seg_n;
    logic [3:0]  dig_n;
    logic        frame_tick;

    modport master (
        output seg_word, enable, brightness, blink_mask,
        input  seg_n, dig_n, frame_tick
    );

    modport slave (
        input  seg_word, enable, brightness, blink_mask,
        output seg_n, dig_n, frame_tick
    );
endinterface

// File: rtl/hex_scan_driver.sv
// Four-digit active-low 7-segment scanner with blank guard, PWM dimming and frame snapshot.
// Optional per-digit blink is built only when HEX_SCAN_BLINK_EN is defined.
module hex_scan_driver #(
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned DRIVE_CYCLES = 49500,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    hex_scan_driver_if.slave bus
);
    localparam int unsigned MaxCycles = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES
                                                                      : DRIVE_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] DriveLast = CntW'(DRIVE_CYCLES - 1);

    typedef enum logic {StBlank, StDrive} state_e;

    state_e            state_q;
    logic [1:0]        digit_q;
    logic [CntW-1:0]   cnt_q;
    logic [3:0]        pwm_q;
    logic [31:0]       snap_q;
    logic [7:0]        seg_n_q;
    logic [3:0]        dig_n_q;
    logic              tick_q;

    logic              slot_last;
    logic              frame_end;
    logic              frame_start;
    logic              pwm_on;
    logic              blink_off;
    logic              seg_on;
    logic [7:0]        cur_byte;

    always_comb begin
        slot_last   = (state_q == StBlank) ? (cnt_q == BlankLast) : (cnt_q == DriveLast);
        frame_end   = (state_q == StDrive) && slot_last && (digit_q == 2'd3);
        frame_start = (state_q == StBlank) && (digit_q == 2'd0) && (cnt_q == '0);
        cur_byte    = snap_q[{digit_q, 3'b000} +: 8];
        pwm_on      = (bus.brightness == 4'hF) || (pwm_q < bus.brightness);
        seg_on      = pwm_on && !blink_off;
    end

`ifdef HEX_SCAN_BLINK_EN
    localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

    logic [FrameW-1:0] frame_cnt_q;
    logic              blink_phase_q;

    assign blink_off = blink_phase_q && bus.blink_mask[digit_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (!bus.enable) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt_q == FrameLast) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end
`else
    logic unused_blink_mask;

    assign unused_blink_mask = ^bus.blink_mask;
    assign blink_off         = 1'b0;
`endif

    // Outputs are computed from the pre-edge state, giving one cycle of pin latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StBlank;
            digit_q <= 2'd0;
            cnt_q   <= '0;
            pwm_q   <= 4'd0;
            snap_q  <= 32'hFFFF_FFFF;
            seg_n_q <= 8'hFF;
            dig_n_q <= 4'hF;
            tick_q  <= 1'b0;
        end else begin
            pwm_q  <= pwm_q + 4'd1;
            tick_q <= 1'b0;

            if (frame_start) begin
                snap_q <= bus.seg_word;
            end

            if (state_q == StDrive) begin
                dig_n_q <= ~(4'b0001 << digit_q);
                seg_n_q <= seg_on ? cur_byte : 8'hFF;
            end else begin
                dig_n_q <= 4'hF;
                seg_n_q <= 8'hFF;
            end

            if (!bus.enable) begin
                state_q <= StBlank;
                digit_q <= 2'd0;
                cnt_q   <= '0;
            end else if (slot_last) begin
                cnt_q <= '0;
                if (state_q == StBlank) begin
                    state_q <= StDrive;
                end else begin
                    state_q <= StBlank;
                    digit_q <= digit_q + 2'd1;
                    tick_q  <= frame_end;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.seg_n      = seg_n_q;
    assign bus.dig_n      = dig_n_q;
    assign bus.frame_tick = tick_q;
endmodule
